// File: rtl/dest_data_mux.sv
// rtl/dest_data_mux.sv - routes the source stream chosen by each sequence entry to one registered output
// Optional feature: define DEST_MUX_LAST_GEN_EN to derive m_axis_tlast from the beat count.
module dest_data_mux #(
  parameter int DATA_BITS = 512,
  parameter int N_DESTS   = 4,
  parameter int PID_BITS  = 6,
  parameter int LEN_BITS  = 16,
  localparam int DEST_BITS = (N_DESTS > 1) ? $clog2(N_DESTS) : 1,
  localparam int KEEP_BITS = DATA_BITS / 8
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           mux_valid,
  output logic                           mux_ready,
  input  logic [PID_BITS-1:0]            mux_pid,
  input  logic [LEN_BITS-1:0]            mux_len,
  input  logic [DEST_BITS-1:0]           mux_dest,
  input  logic [N_DESTS-1:0]             s_axis_tvalid,
  output logic [N_DESTS-1:0]             s_axis_tready,
  input  logic [N_DESTS*DATA_BITS-1:0]   s_axis_tdata,
  input  logic [N_DESTS*KEEP_BITS-1:0]   s_axis_tkeep,
  input  logic [N_DESTS-1:0]             s_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [DATA_BITS-1:0]           m_axis_tdata,
  output logic [KEEP_BITS-1:0]           m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic [PID_BITS-1:0]            m_axis_tid
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [DEST_BITS-1:0]   dest_q;
  logic [PID_BITS-1:0]    pid_q;
  logic [LEN_BITS-1:0]    cnt_q;

  logic                   out_valid_q;
  logic [DATA_BITS-1:0]   out_data_q;
  logic [KEEP_BITS-1:0]   out_keep_q;
  logic                   out_last_q;
  logic [PID_BITS-1:0]    out_tid_q;

  logic                   entry_acc;
  logic                   src_ready;
  logic                   beat_acc;
  logic                   beat_last;
  logic                   sel_valid;
  logic                   sel_last;
  logic [DATA_BITS-1:0]   sel_data;
  logic [KEEP_BITS-1:0]   sel_keep;
  logic [DEST_BITS-1:0]   dest_in;

  // Out-of-range destinations fall back to source 0.
  always_comb begin
    dest_in = mux_dest;
    if ({1'b0, mux_dest} >= (DEST_BITS + 1)'(N_DESTS)) begin
      dest_in = '0;
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int i = 0; i < N_DESTS; i++) begin
      if (dest_q == DEST_BITS'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*DATA_BITS +: DATA_BITS];
        sel_keep  = s_axis_tkeep[i*KEEP_BITS +: KEEP_BITS];
      end
    end
  end

  assign mux_ready = !areset && (state_q == IDLE);
  assign entry_acc = mux_valid && mux_ready;
  // A source beat may enter only when the output slot is free or being emptied this cycle.
  assign src_ready = !areset && (state_q == XFER) && (!out_valid_q || m_axis_tready);
  assign beat_acc  = src_ready && sel_valid;

  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < N_DESTS; i++) begin
      s_axis_tready[i] = src_ready && (dest_q == DEST_BITS'(i));
    end
  end

`ifdef DEST_MUX_LAST_GEN_EN
  logic unused_src_last;
  assign unused_src_last = sel_last;
  assign beat_last       = (cnt_q == '0);
`else
  assign beat_last = sel_last;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (entry_acc) state_d = XFER;
      XFER:    if (beat_acc && (cnt_q == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      dest_q  <= '0;
      pid_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (entry_acc) begin
        dest_q <= dest_in;
        pid_q  <= mux_pid;
        cnt_q  <= mux_len;
      end else if (beat_acc && (cnt_q != '0)) begin
        cnt_q <= cnt_q - LEN_BITS'(1);
      end
    end
  end

  // Output slot drains on its own, independent of the sequencing state.
  always_ff @(posedge aclk) begin
    if (areset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_tid_q   <= '0;
    end else if (beat_acc) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_keep_q  <= sel_keep;
      out_last_q  <= beat_last;
      out_tid_q   <= pid_q;
    end else if (m_axis_tready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tid    = out_tid_q;

endmodule

// File: tb/tb_dest_data_mux.sv
// tb/tb_dest_data_mux.sv - randomized scoreboard bench for dest_data_mux
module tb_dest_data_mux;
  localparam int DW = 32;
  localparam int N  = 3;
  localparam int PW = 6;
  localparam int LW = 4;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [PW-1:0] id;
  } beat_t;

  logic            aclk, areset;
  logic            mux_valid, mux_ready;
  logic [PW-1:0]   mux_pid;
  logic [LW-1:0]   mux_len;
  logic [1:0]      mux_dest;
  logic [N-1:0]    s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N*KW-1:0] s_axis_tkeep;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic [PW-1:0]   m_axis_tid;

  logic [DW-1:0]   sd [N];
  logic [KW-1:0]   sk [N];
  logic            sl [N];
  logic            sv [N];
  logic            pend [N];

  beat_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  dest_data_mux #(.DATA_BITS(DW), .N_DESTS(N), .PID_BITS(PW), .LEN_BITS(LW)) dut (
    .aclk(aclk), .areset(areset),
    .mux_valid(mux_valid), .mux_ready(mux_ready), .mux_pid(mux_pid),
    .mux_len(mux_len), .mux_dest(mux_dest),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      s_axis_tvalid[i]          = sv[i];
      s_axis_tlast[i]           = sl[i];
      s_axis_tdata[i*DW +: DW]  = sd[i];
      s_axis_tkeep[i*KW +: KW]  = sk[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive sources/sink/entry, check the output slot against the scoreboard, advance.
  task automatic tick(input int sel, input int vprob, input int rmode, input logic gen_last,
                      input logic [PW-1:0] pid, input logic mv, input logic [PW-1:0] mp,
                      input logic [LW-1:0] ml, input logic [1:0] md,
                      output logic hs, output logic rdy);
    logic         out_hs;
    logic [N-1:0] mask;
    beat_t        b;
    @(negedge aclk);
    for (int i = 0; i < N; i++) begin
      if (i == sel) begin
        if (!pend[i] && ($urandom_range(99) < vprob)) begin
          pend[i] = 1'b1;
          sd[i]   = $urandom;
          sk[i]   = KW'($urandom);
          sl[i]   = 1'($urandom);
        end
        sv[i] = pend[i];
      end else begin
        pend[i] = 1'b0;
        sv[i]   = 1'($urandom);
        sd[i]   = $urandom;
        sk[i]   = KW'($urandom);
        sl[i]   = 1'($urandom);
      end
    end
    case (rmode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'($urandom);
    endcase
    mux_valid = mv;
    mux_pid   = mp;
    mux_len   = ml;
    mux_dest  = md;
    #1;
    check("out_valid", m_axis_tvalid, exp_q.size() != 0);
    if (m_axis_tvalid && exp_q.size() != 0)
      check("out_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid}, exp_q[0]);
    mask = '0;
    mask[sel] = 1'b1;
    check("unsel_ready", s_axis_tready & ~mask, '0);
    rdy    = mux_ready;
    hs     = sv[sel] && s_axis_tready[sel];
    out_hs = m_axis_tvalid && m_axis_tready;
    @(posedge aclk);
    if (out_hs && exp_q.size() != 0) void'(exp_q.pop_front());
    if (hs) begin
      b.d  = sd[sel];
      b.k  = sk[sel];
`ifdef DEST_MUX_LAST_GEN_EN
      b.l  = gen_last;
`else
      b.l  = sl[sel];
`endif
      b.id = pid;
      exp_q.push_back(b);
      pend[sel] = 1'b0;
    end
  endtask

  task automatic run_xfer(input logic [PW-1:0] pid, input int len, input int dest, input int vprob,
                          input int rmode, input logic hold, input int abort_at);
    int   sel;
    int   acc;
    int   budget;
    logic hs, rdy;
    sel    = (dest >= N) ? 0 : dest;
    acc    = 0;
    budget = 40 * (len + 1) + 40;
    tick(sel, vprob, rmode, 1'b0, pid, 1'b1, pid, LW'(len), 2'(dest), hs, rdy);
    check("entry_ready", rdy, 1);
    check("idle_accept", hs, 0);
    while (acc <= len) begin
      if (abort_at >= 0 && acc == abort_at) return;
      if (budget == 0) begin
        check("xfer_timeout", acc, len + 1);
        return;
      end
      budget--;
      tick(sel, vprob, rmode, acc == len, pid, hold, PW'($urandom), LW'($urandom), 2'($urandom), hs, rdy);
      check("xfer_ready", rdy, 0);
      if (hs) acc++;
    end
  endtask

  task automatic drain();
    int   budget;
    logic hs, rdy;
    budget = 40;
    while (exp_q.size() != 0 && budget > 0) begin
      tick(0, 0, 0, 1'b0, '0, 1'b0, '0, '0, '0, hs, rdy);
      check("drain_accept", hs, 0);
      budget--;
    end
    check("drain_left", exp_q.size(), 0);
    tick(0, 0, 0, 1'b0, '0, 1'b0, '0, '0, '0, hs, rdy);
    check("idle_ready", rdy, 1);
  endtask

  task automatic check_reset_regs();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tkeep", m_axis_tkeep, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tid", m_axis_tid, 0);
    check("rst_mux_ready", mux_ready, 0);
    check("rst_s_tready", s_axis_tready, 0);
  endtask

  initial begin
    areset = 1'b1;
    mux_valid = 1'b0; mux_pid = '0; mux_len = '0; mux_dest = '0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < N; i++) begin
      sd[i] = '0; sk[i] = '0; sl[i] = 1'b0; sv[i] = 1'b0; pend[i] = 1'b0;
    end
    repeat (3) @(posedge aclk);
    @(negedge aclk); #1;
    check_reset_regs();
    areset = 1'b0; #1;
    check("rel_mux_ready", mux_ready, 1);

    run_xfer(3, 3, 2, 100, 0, 1'b0, -1); drain();
    run_xfer(9, 0, 0, 100, 0, 1'b1, -1);
    run_xfer(10, 1, 1, 100, 0, 1'b1, -1); drain();
    run_xfer(21, 7, 1, 100, 1, 1'b0, -1); drain();
    run_xfer(33, 2, 3, 70, 2, 1'b0, -1); drain();
    run_xfer(44, 15, 2, 80, 0, 1'b1, -1); drain();
    for (int t = 0; t < 25; t++) begin
      run_xfer(PW'($urandom), int'($urandom_range(15)), int'($urandom_range(3)),
               int'($urandom_range(100, 40)), int'($urandom_range(2)), 1'($urandom), -1);
      if ($urandom_range(1) == 1) drain();
    end
    drain();

    run_xfer(50, 5, 1, 100, 0, 1'b0, 2);
    @(negedge aclk);
    areset = 1'b1; #1;
    check("midrst_mux_ready", mux_ready, 0);
    check("midrst_s_tready", s_axis_tready, 0);
    @(negedge aclk); #1;
    check_reset_regs();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; sv[i] = 1'b0;
    end
    areset = 1'b0; #1;
    check("midrst_rel_ready", mux_ready, 1);
    run_xfer(51, 0, 2, 100, 0, 1'b0, -1); drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dest_data_mux.md
DEST_DATA_MUX -- requirements
Module: dest_data_mux

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named aclk and areset.
REQ-002 Parameters (name, default, meaning), SHALL be:
- DATA_BITS, 512, data beat width.
- N_DESTS, 4, number of source streams.
- PID_BITS, 6, process ID width.
- LEN_BITS, 16, beat-count width.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- aclk, in, 1, clock.
- areset, in, 1, sync active-high reset.
- mux_valid, in, 1, sequence entry valid.
- mux_ready, out, 1, sequence entry accept.
- mux_pid, in, PID_BITS, process ID of the transfer.
- mux_len, in, LEN_BITS, beats minus one.
- mux_dest, in, clog2s(N_DESTS), selected source index.
- s_axis_tvalid, in, N_DESTS, per-source valid.
- s_axis_tready, out, N_DESTS, per-source ready.
- s_axis_tdata, in, N_DESTS*DATA_BITS, per-source data.
- s_axis_tkeep, in, N_DESTS*DATA_BITS/8, per-source keep.
- s_axis_tlast, in, N_DESTS, per-source last.
- m_axis_tvalid, out, 1, output valid.
- m_axis_tready, in, 1, output ready.
- m_axis_tdata, out, DATA_BITS, output data.
- m_axis_tkeep, out, DATA_BITS/8, output keep.
- m_axis_tlast, out, 1, output last.
- m_axis_tid, out, PID_BITS, pid of the current transfer.

Function
REQ-004 The FSM SHALL have two states, IDLE and XFER.
REQ-005 In IDLE, mux_ready SHALL be 1; in XFER, mux_ready SHALL be 0.
REQ-006 On mux_valid&mux_ready, the block SHALL latch dest, pid and cnt=mux_len, and enter XFER on the next cycle.
REQ-007 In XFER, s_axis_tready[dest] SHALL be 1 when output register empty or m_axis_tready=1; all other s_axis_tready bits SHALL be 0 at all times.
REQ-008 Each accepted source beat SHALL load the single-stage output register; latency from source to m_axis SHALL be exactly 1 cycle.
REQ-009 m_axis_tvalid SHALL stay asserted and m_axis_t* SHALL stay stable until m_axis_tready=1.
REQ-010 m_axis_tid SHALL equal the latched pid for every beat of the transfer.
REQ-011 On each accepted beat with cnt!=0, cnt SHALL decrement by 1.
REQ-012 On the accepted beat with cnt==0, the FSM SHALL return to IDLE; the next entry SHALL NOT be accepted in that same cycle (one-cycle bubble minimum between transfers).
REQ-013 The output register SHALL drain independently of the FSM state; a beat held at IDLE entry SHALL NOT be lost or duplicated.
REQ-014 mux_len=0 SHALL produce exactly one beat; mux_len=2^LEN_BITS-1 SHALL produce 2^LEN_BITS beats with no counter wrap.
REQ-015 A mux_dest value >= N_DESTS SHALL be treated as source 0.
REQ-016 Source valid on unselected sources SHALL be ignored and SHALL NOT affect output.

Reset
REQ-017 While areset=1, the block SHALL go to IDLE with cnt=0, dest=0, pid=0, m_axis_tvalid=0, all s_axis_tready=0, mux_ready=0, and m_axis_tdata/tkeep/tlast/tid=0.
REQ-018 Reset mid-transfer SHALL discard the in-flight beat and remaining count.
REQ-019 mux_ready SHALL be 1 in the first cycle after areset deasserts.

Configuration
REQ-020 With DEST_MUX_LAST_GEN_EN defined, m_axis_tlast SHALL be 1 only on the beat accepted with cnt==0, and source tlast SHALL be ignored.
REQ-021 With DEST_MUX_LAST_GEN_EN undefined, m_axis_tlast SHALL pass through the selected source tlast unmodified; transfer end SHALL still be decided by cnt only.

Verification
REQ-022 Entry {pid=3, len=3, dest=2}, source 2 streams 4 beats D0..D3 continuously, m_axis_tready=1 -> four output beats D0..D3, each 1 cycle after its source beat, tid=3, tlast only on D3 (LAST_GEN_EN), then back in IDLE.
REQ-023 Two back-to-back entries {dest=0, len=0} and {dest=1, len=1} -> one beat from source 0, then two beats from source 1, mux_ready=0 during XFER, at least one cycle gap between the transfers.
REQ-024 m_axis_tready toggles 1/0 each cycle during an 8-beat transfer -> 8 beats output in order, none dropped or duplicated, data stable while stalled.
REQ-025 Sources 0,1,3 hold tvalid=1 throughout while dest=2 is selected -> their tready remains 0 and no beats from them appear on the output.
REQ-026 areset pulsed after beat 2 of a 6-beat transfer -> all outputs reset values next cycle, mux_ready=1 after release, a new entry with len=0 yields exactly one beat.
